// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state encodings, forward-select codes and the register match helper
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  function automatic logic match(logic wen, logic [4:0] waddr, logic [4:0] saddr, logic used);
    return wen && waddr == saddr && saddr != 5'd0 && used;
  endfunction
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: operand match, forward-select and stall-request logic
// PIPE_FORWARD_EN selects forwarding; without it every in-flight match stalls.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] exe_wb_addr,
  input  logic       exe_wb_wen,
  input  logic       exe_mem_ren,
  input  logic [4:0] mem_wb_addr,
  input  logic       mem_wb_wen,
  input  logic [4:0] wb_wb_addr,
  input  logic       wb_wb_wen,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       hazard
);
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, load_use;
  always_comb begin
    ex_a = match(exe_wb_wen, exe_wb_addr, id_rs_addr, id_rs_used);
    ex_b = match(exe_wb_wen, exe_wb_addr, id_rt_addr, id_rt_used);
    mem_a = match(mem_wb_wen, mem_wb_addr, id_rs_addr, id_rs_used);
    mem_b = match(mem_wb_wen, mem_wb_addr, id_rt_addr, id_rt_used);
    wb_a = match(wb_wb_wen, wb_wb_addr, id_rs_addr, id_rs_used);
    wb_b = match(wb_wb_wen, wb_wb_addr, id_rt_addr, id_rt_used);
    load_use = exe_mem_ren && (ex_a || ex_b);
`ifdef PIPE_FORWARD_EN
    hazard = load_use;
    fwd_a_sel = (ex_a && !exe_mem_ren) ? FWD_EXE : mem_a ? FWD_MEM : wb_a ? FWD_WB : FWD_REG;
    fwd_b_sel = (ex_b && !exe_mem_ren) ? FWD_EXE : mem_b ? FWD_MEM : wb_b ? FWD_WB : FWD_REG;
`else
    hazard = load_use || ex_a || ex_b || mem_a || mem_b || wb_a || wb_b;
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
`endif
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline controller (stall/flush/forward, memory-wait FSM, stall counter)
// Build with PIPE_FORWARD_EN to enable operand forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        cpu_en,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  exe_wb_addr,
  input  logic        exe_wb_wen,
  input  logic        exe_mem_ren,
  input  logic [4:0]  mem_wb_addr,
  input  logic        mem_wb_wen,
  input  logic [4:0]  wb_wb_addr,
  input  logic        wb_wb_wen,
  input  logic        id_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        id_flush,
  output logic        exe_bubble,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [1:0]  state
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  state_t cur, nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [31:0] cnt;
  logic [1:0] fa, fb;
  logic hazard, run;
  hazard_detect u_hazard (
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen), .exe_mem_ren(exe_mem_ren),
    .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen),
    .wb_wb_addr(wb_wb_addr), .wb_wb_wen(wb_wb_wen),
    .fwd_a_sel(fa), .fwd_b_sel(fb), .hazard(hazard)
  );
  always_comb begin
    nxt = cur;
    wait_nxt = wait_cnt;
    if (cur == RUN && mem_req && !mem_ack) nxt = MEM_WAIT;
    if (cur == MEM_WAIT) begin
      wait_nxt = mem_ack ? 8'd0 : wait_cnt + 8'd1;
      nxt = mem_ack ? RUN : (wait_cnt + 8'd1 == TIMEOUT) ? ERROR : MEM_WAIT;
    end
  end
  // Reset dominates every output so the pipeline is held in NOPs while cpu_rst is high.
  assign run = !cpu_rst && cpu_en && cur == RUN;
  assign if_en = run && !hazard;
  assign id_en = run && !hazard;
  assign exe_en = run;
  assign mem_en = run;
  assign wb_en = run;
  assign exe_bubble = cpu_rst || (run && hazard);
  assign id_flush = cpu_rst || (run && !hazard && id_branch_taken);
  assign fwd_a_sel = cpu_rst ? FWD_REG : fa;
  assign fwd_b_sel = cpu_rst ? FWD_REG : fb;
  assign mem_err = !cpu_rst && cur == ERROR;
  assign state = cpu_rst ? RUN : cur;
  assign stall_cnt = cpu_rst ? 32'd0 : cnt;
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      cur <= RUN;
      wait_cnt <= 8'd0;
      cnt <= 32'd0;
    end else if (cpu_en) begin
      cur <= nxt;
      wait_cnt <= wait_nxt;
      if (!if_en) cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max consecutive MEM_WAIT cycles before error (range 1..255).
REQ-002 clk  in  1  main clock; all state updates on rising edge.
REQ-003 cpu_rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_en  in  1  global advance enable; 0 freezes all state.
REQ-005 id_rs_addr / id_rt_addr  in  5 each  ID-stage source registers; id_rs_used / id_rt_used  in  1 each  source actually read.
REQ-006 exe_wb_addr  in  5, exe_wb_wen  in  1, exe_mem_ren  in  1  EX-stage destination, write enable, load flag.
REQ-007 mem_wb_addr  in  5, mem_wb_wen  in  1; wb_wb_addr  in  5, wb_wb_wen  in  1  MEM/WB-stage destinations.
REQ-008 id_branch_taken  in  1  branch/jump resolved taken in ID.
REQ-009 mem_req  in  1  MEM stage issuing a data access; mem_ack  in  1  access completes this cycle.
REQ-010 if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage register load enables.
REQ-011 id_flush  out  1  IF/ID loads NOP; exe_bubble  out  1  ID/EX loads NOP.
REQ-012 fwd_a_sel, fwd_b_sel  out  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data.
REQ-013 mem_err  out  1  sticky memory timeout; stall_cnt  out  32  total stall cycles; state  out  2  debug.

Function
REQ-014 States: RUN(00), MEM_WAIT(01), ERROR(10); register 0 never matches any hazard.
REQ-015 Match(X,s) = X_wen && X_addr==s_addr && s_addr!=0 && s_used.
REQ-016 RUN, no hazard: all five enables 1, id_flush=0, exe_bubble=0.
REQ-017 Load-use (EX match with exe_mem_ren=1): if_en=id_en=0, exe_bubble=1, exe/mem/wb_en=1, for exactly one cycle per load.
REQ-018 Branch taken in RUN with no stall: id_flush=1, all enables 1; during a stall id_branch_taken is ignored (re-evaluated once operands ready).
REQ-019 RUN -> MEM_WAIT when mem_req=1 && mem_ack=0; mem_req with mem_ack=1 same cycle completes with no stall.
REQ-020 MEM_WAIT: all enables 0, id_flush=exe_bubble=0; wait counter increments each cycle; mem_ack=1 -> RUN next cycle, counter cleared.
REQ-021 Counter reaching MEM_TIMEOUT without ack -> ERROR; ack in that same cycle wins (-> RUN).
REQ-022 ERROR: all enables 0, mem_err=1; exits only via cpu_rst.
REQ-023 Priority: ERROR > MEM_WAIT/mem stall > load-use stall > branch flush.
REQ-024 cpu_en=0: all enables 0, flush/bubble 0, state, wait counter and stall_cnt held.
REQ-025 stall_cnt increments (wrap at 2^32) every cpu_en cycle, outside reset, with if_en=0.
REQ-026 Enables, flush, bubble, fwd selects are combinational from inputs and registered state; zero added latency.

Reset
REQ-027 While cpu_rst=1: state=RUN, wait counter=0, stall_cnt=0, mem_err=0, all enables 0, id_flush=1, exe_bubble=1, fwd selects 00.
REQ-028 cpu_rst mid-MEM_WAIT or ERROR returns to RUN next cycle regardless of mem_ack.

Configuration
REQ-029 Macro PIPE_FORWARD_EN defined: fwd selects per EX>MEM>WB match priority (EX not selected when exe_mem_ren=1); only load-use stalls.
REQ-030 PIPE_FORWARD_EN undefined: fwd selects tied 00; any EX, MEM or WB match stalls as REQ-017 (if_en=id_en=0, exe_bubble=1) until no match remains.

Structure
REQ-031 State encodings, FWD_* select codes shared in mips_define.vh alongside existing PC_*/WB_* constants.
REQ-032 One combinational sub-module hazard_detect (match and forward-select logic); FSM, counters in pipe_ctrl.

Verification
REQ-033 Load r8 in EX, ID uses rs=r8 -> one cycle if_en=0, exe_bubble=1; next cycle fwd_a_sel=10; stall_cnt=1.
REQ-034 Forward build, add r9 in EX, ID rt=r9 (non-load) -> fwd_b_sel=01, no stall; rt=r0 with EX writing r0 -> fwd_b_sel=00.
REQ-035 mem_req=1, mem_ack low 3 cycles then high -> MEM_WAIT 3 cycles, all enables 0, RUN on 4th, stall_cnt=3.
REQ-036 MEM_TIMEOUT=4, mem_ack never -> ERROR after 4 wait cycles, mem_err=1; cpu_rst pulse -> RUN, mem_err=0.
REQ-037 Taken branch during load-use stall -> no id_flush that cycle; id_flush=1 the following cycle.
REQ-038 Non-forward build, MEM writes r5, ID rs=r5 -> stall until match clears (2 cycles), fwd selects stay 00.
